pseudo_spi_dma: RTL and testbench

PSEUDO_SPI_DMA -- requirements
Module: pseudo_spi_dma

---
 rtl/pseudo_spi_dma_if.sv | 37 +++
 rtl/pseudo_spi_dma.sv | 121 ++++++++++++
 tb/tb_pseudo_spi_dma.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pseudo_spi_dma_if.sv
// Host control, SRAM port and two-phase serial lines of pseudo_spi_dma.
// The DMA engine connects through the master modport; the host/SRAM side uses slave.
interface pseudo_spi_dma_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 8,
  parameter int DIV_WIDTH  = 8
);
  logic                  BGN;
  logic                  MODE;
  logic                  LSB_FIRST;
  logic [ADDR_WIDTH-1:0] ADDR_BGN;
  logic [LEN_WIDTH-1:0]  DATA_LEN;
  logic [DIV_WIDTH-1:0]  FREQ_DIV;
  logic                  SPI_SI;
  logic [DATA_WIDTH-1:0] PI;
  logic                  SCLK1;
  logic                  SCLK2;
  logic                  LAT;
  logic                  SPI_SO;
  logic                  CEN;
  logic                  WEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] PO;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    input  BGN, MODE, LSB_FIRST, ADDR_BGN, DATA_LEN, FREQ_DIV, SPI_SI, PI,
    output SCLK1, SCLK2, LAT, SPI_SO, CEN, WEN, A, PO, BUSY, DONE
  );

  modport slave (
    output BGN, MODE, LSB_FIRST, ADDR_BGN, DATA_LEN, FREQ_DIV, SPI_SI, PI,
    input  SCLK1, SCLK2, LAT, SPI_SO, CEN, WEN, A, PO, BUSY, DONE
  );
endinterface

// File: rtl/pseudo_spi_dma.sv
// SRAM <-> serial DMA engine: streams DATA_LEN words between a single-port SRAM
// and a two-phase (SCLK1/SCLK2) serial link, one word per DATA_WIDTH bit periods.
module pseudo_spi_dma #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  pseudo_spi_dma_if.master bus
);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]            state, state_nxt;
  logic                  mode_q, lsb_q;
  logic [DIV_WIDTH-1:0]  div_q, div_cnt;
  logic [1:0]            phase;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  rem;
  logic                  running, tick, frame_end, last_word, sram_sel;

  assign running   = (state == S_SHIFT) || (state == S_LATCH);
  assign tick      = running && (div_cnt == div_q);
  assign frame_end = tick && (phase == 2'd3) && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign last_word = (rem == LEN_WIDTH'(1));
  assign sram_sel  = (state == S_ADDR) || (state == S_WRITE);

  // Dropping BGN returns to IDLE from every state: abort when busy, acknowledge in DONE.
  always_comb begin
    state_nxt = state;
    if (!bus.BGN) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = (bus.DATA_LEN == '0) ? S_DONE : (bus.MODE ? S_SHIFT : S_ADDR);
        S_ADDR:  state_nxt = S_READ;
        S_READ:  state_nxt = S_SHIFT;
        S_SHIFT: if (frame_end) state_nxt = mode_q ? S_WRITE : S_LATCH;
        S_LATCH: if (tick) state_nxt = last_word ? S_DONE : S_NEXT;
        S_WRITE: state_nxt = last_word ? S_DONE : S_NEXT;
        S_NEXT:  state_nxt = mode_q ? S_SHIFT : S_ADDR;
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      lsb_q   <= 1'b0;
      div_q   <= '0;
      div_cnt <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      addr    <= '0;
      rem     <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && bus.BGN) begin
        mode_q <= bus.MODE;
        lsb_q  <= bus.LSB_FIRST;
        div_q  <= bus.FREQ_DIV;
        addr   <= bus.ADDR_BGN;
        rem    <= bus.DATA_LEN;
      end

      // Every exit from SHIFT/LATCH happens on a tick, so this also clears on entry.
      div_cnt <= (running && !tick) ? div_cnt + DIV_WIDTH'(1) : '0;

      if (state != S_SHIFT) begin
        phase   <= '0;
        bit_cnt <= '0;
      end else if (tick) begin
        phase <= phase + 2'd1;
        if (phase == 2'd3) bit_cnt <= bit_cnt + BIT_W'(1);
      end

      if (state == S_READ) begin
        shreg <= bus.PI;
      end else if (state == S_SHIFT && tick) begin
        if (!mode_q && phase == 2'd3)
          shreg <= lsb_q ? {1'b0, shreg[DATA_WIDTH-1:1]} : {shreg[DATA_WIDTH-2:0], 1'b0};
        else if (mode_q && phase == 2'd2)
          shreg <= lsb_q ? {bus.SPI_SI, shreg[DATA_WIDTH-1:1]} : {shreg[DATA_WIDTH-2:0], bus.SPI_SI};
      end

      if (state == S_NEXT) begin
        addr <= addr + ADDR_WIDTH'(1);
        rem  <= rem - LEN_WIDTH'(1);
      end
    end
  end

  // Outputs decode from registered state only, so an asynchronous reset clears them at once.
  assign bus.SCLK1  = (state == S_SHIFT) && (phase == 2'd0);
  assign bus.SCLK2  = (state == S_SHIFT) && (phase == 2'd2);
  assign bus.LAT    = (state == S_LATCH);
  assign bus.SPI_SO = (state == S_SHIFT) && !mode_q && (lsb_q ? shreg[0] : shreg[DATA_WIDTH-1]);
  assign bus.CEN    = !sram_sel;
  assign bus.WEN    = (state != S_WRITE);
  assign bus.A      = sram_sel ? addr : '0;
  assign bus.PO     = (state == S_WRITE) ? shreg : '0;
  assign bus.BUSY   = (state != S_IDLE) && (state != S_DONE);
  assign bus.DONE   = (state == S_DONE);
endmodule

// File: tb/tb_pseudo_spi_dma.sv
// Self-checking bench for pseudo_spi_dma: behavioural SRAM, serial monitor/driver
// and per-scenario tasks comparing against word-level expectations.
module tb_pseudo_spi_dma;
  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int LW    = 8;
  localparam int FW    = 8;
  localparam int DEPTH = 1 << AW;

  logic CLK = 1'b0;
  logic RST;
  int   n_vec = 0;
  int   n_err = 0;

  pseudo_spi_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DIV_WIDTH(FW)) bus ();

  pseudo_spi_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DIV_WIDTH(FW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // SRAM model: read data appears on PI the cycle after a CEN-low read cycle.
  logic [DW-1:0] mem [DEPTH];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge CLK) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (!bus.CEN) begin
      if (!bus.WEN) mem[bus.A] <= bus.PO;
      else          bus.PI     <= mem[bus.A];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor/driver: samples SPI_SO and drives SPI_SI at each SCLK1 rise, measures pulse widths.
  logic          mon_clr = 1'b0;
  logic          obs_bits [1024];
  logic          si_bits  [1024];
  int            obs_n, si_idx, lat_pulses, wen_low, cen_low, overlap, first_cen, done_cyc;
  int            hi_runs [64];
  int            lo_runs [64];
  int            lat_runs [8];
  int            nh, nl, nlat, s1_cnt, lo_cnt, lat_cnt;
  logic          seen_fall, prev_s1, prev_lat;
  logic [DW-1:0] tw [16];

  always @(negedge CLK) begin
    if (mon_clr) begin
      obs_n = 0; si_idx = 0; lat_pulses = 0; wen_low = 0; cen_low = 0; overlap = 0;
      first_cen = -1; done_cyc = -1; nh = 0; nl = 0; nlat = 0;
      s1_cnt = 0; lo_cnt = 0; lat_cnt = 0;
      seen_fall = 1'b0; prev_s1 = 1'b0; prev_lat = 1'b0; bus.SPI_SI = 1'b0;
    end else begin
      if (bus.SCLK1 && bus.SCLK2) overlap++;
      if (!bus.CEN) begin
        cen_low++;
        if (first_cen < 0) first_cen = cyc;
      end
      if (!bus.WEN) wen_low++;
      if (bus.DONE && done_cyc < 0) done_cyc = cyc;
      if (bus.SCLK1) begin
        if (!prev_s1) begin
          if (obs_n < 1024) obs_bits[obs_n] = bus.SPI_SO;
          obs_n++;
          if (si_idx < 1024) bus.SPI_SI = si_bits[si_idx];
          si_idx++;
          if (seen_fall && nl < 64) begin lo_runs[nl] = lo_cnt; nl++; end
          s1_cnt = 0;
        end
        s1_cnt++;
      end else begin
        if (prev_s1) begin
          if (nh < 64) begin hi_runs[nh] = s1_cnt; nh++; end
          seen_fall = 1'b1;
          lo_cnt = 0;
        end
        lo_cnt++;
      end
      if (bus.LAT) begin
        if (!prev_lat) begin lat_pulses++; lat_cnt = 0; end
        lat_cnt++;
      end else if (prev_lat && nlat < 8) begin
        lat_runs[nlat] = lat_cnt; nlat++;
      end
      prev_s1  = bus.SCLK1;
      prev_lat = bus.LAT;
    end
  end

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge CLK);
    #1 mon_clr = 1'b0;
  endtask

  task automatic sram_poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge CLK);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(negedge CLK);
    pl_we = 1'b0;
  endtask

  task automatic start_xfer(input logic mode, input logic lsb, input logic [AW-1:0] a,
                            input logic [LW-1:0] len, input logic [FW-1:0] f);
    @(negedge CLK);
    bus.MODE = mode; bus.LSB_FIRST = lsb; bus.ADDR_BGN = a; bus.DATA_LEN = len;
    bus.FREQ_DIV = f; bus.BGN = 1'b1;
  endtask

  // Inputs other than BGN are garbage after the start edge and must be ignored.
  task automatic scramble_inputs();
    @(negedge CLK);
    bus.MODE = 1'($urandom); bus.LSB_FIRST = 1'($urandom); bus.ADDR_BGN = AW'($urandom);
    bus.DATA_LEN = LW'($urandom); bus.FREQ_DIV = FW'($urandom);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i = 0;
    while (!bus.DONE && i < budget) begin
      @(negedge CLK); #1; i++;
    end
    n_vec++;
    if (bus.DONE !== 1'b1) begin
      n_err++; $display("FAIL %s done_timeout: DONE=%b after %0d cycles, required 1", tag, bus.DONE, i);
    end
  endtask

  task automatic end_xfer(input string tag);
    @(negedge CLK); bus.BGN = 1'b0;
    @(negedge CLK); #1;
    n_vec++;
    if ({bus.DONE, bus.BUSY} !== 2'b00) begin
      n_err++; $display("FAIL %s ack: DONE,BUSY=%b, required 00", tag, {bus.DONE, bus.BUSY});
    end
  endtask

  task automatic test_reset();
    bus.BGN = 1'b0; bus.MODE = 1'b0; bus.LSB_FIRST = 1'b0; bus.ADDR_BGN = '0;
    bus.DATA_LEN = '0; bus.FREQ_DIV = '0;
    RST = 1'b0;
    #1 RST = 1'b1;
    #2;
    n_vec++;
    if ({bus.SCLK1, bus.SCLK2, bus.LAT, bus.SPI_SO, bus.CEN, bus.WEN, bus.BUSY, bus.DONE} !== 8'b0000_1100) begin
      n_err++; $display("FAIL reset_ctrl: got %b, required 00001100",
                        {bus.SCLK1, bus.SCLK2, bus.LAT, bus.SPI_SO, bus.CEN, bus.WEN, bus.BUSY, bus.DONE});
    end
    n_vec++;
    if (bus.A !== '0) begin n_err++; $display("FAIL reset_A: got %h, required 000", bus.A); end
    n_vec++;
    if (bus.PO !== '0) begin n_err++; $display("FAIL reset_PO: got %h, required 00", bus.PO); end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    mon_clear();
    repeat (2) @(negedge CLK);
    #1;
    n_vec++;
    if ({bus.BUSY, bus.CEN} !== 2'b01) begin
      n_err++; $display("FAIL reset_idle: BUSY,CEN=%b, required 01", {bus.BUSY, bus.CEN});
    end
  endtask

  task automatic test_read(input logic [AW-1:0] a, input int len, input int f,
                           input logic lsb, input string tag);
    int            exp_cyc;
    int            k;
    logic [DW-1:0] got;
    for (int i = 0; i < len; i++) sram_poke(AW'(a + i), tw[i]);
    mon_clear();
    start_xfer(1'b0, lsb, a, LW'(len), FW'(f));
    scramble_inputs();
    wait_done(len * (4 * DW * (f + 1) + f + 4) + 20, tag);
    exp_cyc = len * (3 + 4 * DW * (f + 1) + (f + 1)) - 1;
    n_vec++;
    if (done_cyc - first_cen !== exp_cyc) begin
      n_err++; $display("FAIL %s done_latency: got %0d cycles, required %0d", tag, done_cyc - first_cen, exp_cyc);
    end
    n_vec++;
    if (obs_n !== len * DW) begin
      n_err++; $display("FAIL %s bit_count: got %0d, required %0d", tag, obs_n, len * DW);
    end
    for (int i = 0; i < len; i++) begin
      got = '0;
      for (int b = 0; b < DW; b++) begin
        k = i * DW + b;
        if (k < 1024) begin
          if (lsb) got[b] = obs_bits[k];
          else     got[DW-1-b] = obs_bits[k];
        end
      end
      n_vec++;
      if (got !== tw[i]) begin
        n_err++; $display("FAIL %s so_word%0d: got %h, required %h", tag, i, got, tw[i]);
      end
    end
    n_vec++;
    if ({lat_pulses, cen_low, wen_low, overlap} !== {len, len, 32'sd0, 32'sd0}) begin
      n_err++; $display("FAIL %s strobes: LAT=%0d CENlow=%0d WENlow=%0d overlap=%0d, required %0d %0d 0 0",
                        tag, lat_pulses, cen_low, wen_low, overlap, len, len);
    end
    n_vec++;
    if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done: got %b, required 0", tag, bus.BUSY); end
    end_xfer(tag);
  endtask

  task automatic test_write(input logic [AW-1:0] a, input int len, input int f,
                            input logic lsb, input string tag);
    for (int i = 0; i < len; i++)
      for (int b = 0; b < DW; b++)
        si_bits[i * DW + b] = lsb ? tw[i][b] : tw[i][DW-1-b];
    mon_clear();
    start_xfer(1'b1, lsb, a, LW'(len), FW'(f));
    scramble_inputs();
    wait_done(len * (4 * DW * (f + 1) + 2) + 20, tag);
    for (int i = 0; i < len; i++) begin
      n_vec++;
      if (mem[AW'(a + i)] !== tw[i]) begin
        n_err++; $display("FAIL %s sram[%h]: got %h, required %h", tag, AW'(a + i), mem[AW'(a + i)], tw[i]);
      end
    end
    n_vec++;
    if ({wen_low, cen_low, lat_pulses, overlap, obs_n} !== {len, len, 32'sd0, 32'sd0, len * DW}) begin
      n_err++; $display("FAIL %s strobes: WENlow=%0d CENlow=%0d LAT=%0d overlap=%0d bits=%0d, required %0d %0d 0 0 %0d",
                        tag, wen_low, cen_low, lat_pulses, overlap, obs_n, len, len, len * DW);
    end
    end_xfer(tag);
  endtask

  task automatic test_directed();
    tw[0] = 8'hAB; tw[1] = 8'h3C;
    test_read(9'h020, 2, 0, 1'b1, "rd_ab3c");
    tw[0] = 8'hC2; tw[1] = 8'h01;
    test_write(9'h1FF, 2, 0, 1'b0, "wr_wrap");
  endtask

  task automatic test_timing();
    int bad_hi = 0, bad_lo = 0;
    tw[0] = DW'($urandom);
    test_read(AW'($urandom), 1, 3, 1'($urandom), "timing");
    for (int i = 0; i < nh; i++) if (hi_runs[i] != 4) bad_hi++;
    for (int i = 0; i < nl; i++) if (lo_runs[i] != 12) bad_lo++;
    n_vec++;
    if (nh !== 8 || bad_hi !== 0) begin
      n_err++; $display("FAIL timing_sclk1_high: %0d pulses, %0d not 4 cycles, required 8 pulses all 4", nh, bad_hi);
    end
    n_vec++;
    if (nl !== 7 || bad_lo !== 0) begin
      n_err++; $display("FAIL timing_sclk1_low: %0d gaps, %0d not 12 cycles, required 7 gaps all 12", nl, bad_lo);
    end
    n_vec++;
    if (nlat !== 1 || lat_runs[0] !== 4) begin
      n_err++; $display("FAIL timing_lat: %0d pulses, first %0d cycles, required 1 pulse of 4", nlat, lat_runs[0]);
    end
  endtask

  task automatic test_zero_len();
    mon_clear();
    start_xfer(1'($urandom), 1'($urandom), AW'($urandom), '0, FW'($urandom_range(0, 3)));
    @(negedge CLK); #1;
    n_vec++;
    if ({bus.DONE, bus.BUSY} !== 2'b10) begin
      n_err++; $display("FAIL zero_len_done: DONE,BUSY=%b, required 10", {bus.DONE, bus.BUSY});
    end
    repeat (4) @(negedge CLK);
    #1;
    n_vec++;
    if (bus.DONE !== 1'b1 || cen_low !== 0) begin
      n_err++; $display("FAIL zero_len_hold: DONE=%b CENlow=%0d, required 1 0", bus.DONE, cen_low);
    end
    end_xfer("zero_len");
  endtask

  task automatic test_abort();
    logic [AW-1:0] a;
    logic [DW-1:0] old;
    a = AW'($urandom); old = DW'($urandom);
    sram_poke(a, old);
    tw[0] = ~old;
    for (int b = 0; b < DW; b++) si_bits[b] = tw[0][DW-1-b];
    mon_clear();
    start_xfer(1'b1, 1'b0, a, 8'd1, 8'd1);
    scramble_inputs();
    for (int i = 0; i < 400 && obs_n < 6; i++) begin @(negedge CLK); #1; end
    n_vec++;
    if (obs_n < 6) begin n_err++; $display("FAIL abort_reach_bit5: got %0d bits, required 6", obs_n); end
    bus.BGN = 1'b0;
    @(negedge CLK); #1;
    n_vec++;
    if ({bus.BUSY, bus.DONE, bus.SCLK1, bus.SCLK2, bus.CEN, bus.WEN} !== 6'b000011) begin
      n_err++; $display("FAIL abort_idle: BUSY,DONE,SCLK1,SCLK2,CEN,WEN=%b, required 000011",
                        {bus.BUSY, bus.DONE, bus.SCLK1, bus.SCLK2, bus.CEN, bus.WEN});
    end
    repeat (10) @(negedge CLK);
    #1;
    n_vec++;
    if (wen_low !== 0 || mem[a] !== old) begin
      n_err++; $display("FAIL abort_no_write: WENlow=%0d sram=%h, required 0 %h", wen_low, mem[a], old);
    end
  endtask

  task automatic test_rst_mid();
    logic [AW-1:0] a;
    a = AW'($urandom);
    tw[0] = DW'($urandom); tw[1] = DW'($urandom);
    for (int i = 0; i < 2; i++) sram_poke(AW'(a + i), tw[i]);
    mon_clear();
    start_xfer(1'b0, 1'b1, a, 8'd2, 8'd1);
    for (int i = 0; i < 400 && obs_n < 3; i++) begin @(negedge CLK); #1; end
    n_vec++;
    if (obs_n < 3) begin n_err++; $display("FAIL rst_mid_reach_shift: got %0d bits, required 3", obs_n); end
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    n_vec++;
    if ({bus.SCLK1, bus.SCLK2, bus.LAT, bus.SPI_SO, bus.CEN, bus.WEN, bus.BUSY, bus.DONE} !== 8'b0000_1100
        || bus.A !== '0 || bus.PO !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: ctrl=%b A=%h PO=%h, required 00001100 000 00",
                        {bus.SCLK1, bus.SCLK2, bus.LAT, bus.SPI_SO, bus.CEN, bus.WEN, bus.BUSY, bus.DONE},
                        bus.A, bus.PO);
    end
    bus.BGN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    n_vec++;
    if ({bus.BUSY, bus.CEN} !== 2'b01) begin
      n_err++; $display("FAIL rst_mid_stays_idle: BUSY,CEN=%b, required 01", {bus.BUSY, bus.CEN});
    end
  endtask

  task automatic test_random();
    int            len, f;
    logic          mode, lsb;
    logic [AW-1:0] a;
    for (int it = 0; it < 8; it++) begin
      mode = 1'($urandom); lsb = 1'($urandom);
      len  = $urandom_range(1, 4);
      f    = $urandom_range(0, 2);
      a    = AW'($urandom_range(DEPTH - 3, DEPTH + 2));
      for (int i = 0; i < len; i++) tw[i] = DW'($urandom);
      if (mode) test_write(a, len, f, lsb, "rand_wr");
      else      test_read(a, len, f, lsb, "rand_rd");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timing();
    test_zero_len();
    test_abort();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
